// File: rtl/calc_pkg.sv
// Shared op-code enumeration, radix constants and control state for the RPN stack.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_DIGIT = 3'd1,
        OP_PUSH  = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_MUL   = 3'd5,
        OP_SWAP  = 3'd6,
        OP_CLEAR = 3'd7
    } op_e;

    localparam int unsigned RADIX_DEC = 10;
    localparam int unsigned RADIX_HEX = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/rpn_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, done flags the final step.
// Only compiled when RPN_STACK_MUL_EN is defined.
`ifdef RPN_STACK_MUL_EN
module rpn_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int SW = $clog2(WIDTH + 1);

    logic             busy;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SW-1:0]    step;

    // product is the accumulator after the current step, so the last step can be written back directly
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (step == SW'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            step   <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            step   <= '0;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            step   <= step + SW'(1);
            if (done)
                busy <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/rpn_stack.sv
// RPN calculator stack with digit entry, add/sub/swap/clear and sticky error.
// Define RPN_STACK_MUL_EN to enable the sequential WIDTH-cycle MUL.
module rpn_stack
    import calc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [2:0]                 op_code,
    input  logic [3:0]                 digit,
    input  logic                       hex_mode,
    output logic [WIDTH-1:0]           top,
    output logic [WIDTH-1:0]           next,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       error
);
    localparam int CW = $clog2(DEPTH + 1);

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] stk     [DEPTH];
    logic [WIDTH-1:0] stk_nxt [DEPTH];
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_nxt;
    logic             err_q;
    logic             err_nxt;

    logic             accept;
    logic             mul_go;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [4:0]       radix;
    logic [WIDTH+4:0] dig_wide;
    logic             dig_bad;
    logic             do_pop;
    logic [WIDTH-1:0] pop_val;

    assign accept = op_valid && op_ready;

`ifdef RPN_STACK_MUL_EN
    assign mul_go = accept && (op_e'(op_code) == OP_MUL) && (cnt_q >= CW'(2));

    rpn_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_go),
        .a       (stk[1]),
        .b       (stk[0]),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign mul_go      = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    always_ff @(posedge clock) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mul_go)   state_nxt = ST_MUL;
            ST_MUL:  if (mul_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        op_ready = (state == ST_IDLE);
    end

    // width-extended digit accumulation exposes overflow in the upper five bits
    assign radix    = hex_mode ? 5'(RADIX_HEX) : 5'(RADIX_DEC);
    assign dig_wide = ({5'd0, stk[0]} * {{WIDTH{1'b0}}, radix}) + {{(WIDTH+1){1'b0}}, digit};
    assign dig_bad  = ({1'b0, digit} >= radix) || (|dig_wide[WIDTH+4:WIDTH]);

    always_comb begin
        stk_nxt = stk;
        cnt_nxt = cnt_q;
        err_nxt = err_q;
        do_pop  = 1'b0;
        pop_val = '0;
        if (state == ST_MUL) begin
            if (mul_done) begin
                do_pop  = 1'b1;
                pop_val = mul_product;
            end
        end else if (op_valid) begin
            case (op_e'(op_code))
                OP_DIGIT: begin
                    if (dig_bad)
                        err_nxt = 1'b1;
                    else
                        stk_nxt[0] = dig_wide[WIDTH-1:0];
                end
                OP_PUSH: begin
                    if (cnt_q == CW'(DEPTH)) begin
                        err_nxt = 1'b1;
                    end else begin
                        for (int unsigned i = 1; i < DEPTH; i++)
                            stk_nxt[i] = stk[i-1];
                        stk_nxt[0] = '0;
                        cnt_nxt    = cnt_q + CW'(1);
                    end
                end
                OP_ADD, OP_SUB: begin
                    if (cnt_q < CW'(2)) begin
                        err_nxt = 1'b1;
                    end else begin
                        do_pop  = 1'b1;
                        pop_val = (op_e'(op_code) == OP_ADD) ? (stk[1] + stk[0]) : (stk[1] - stk[0]);
                    end
                end
                OP_MUL: begin
                    // the enabled path only raises error here; the operation itself runs in ST_MUL
                    if (!mul_go)
                        err_nxt = 1'b1;
                end
                OP_SWAP: begin
                    if (cnt_q < CW'(2)) begin
                        err_nxt = 1'b1;
                    end else begin
                        stk_nxt[0] = stk[1];
                        stk_nxt[1] = stk[0];
                    end
                end
                OP_CLEAR: begin
                    for (int unsigned i = 0; i < DEPTH; i++)
                        stk_nxt[i] = '0;
                    cnt_nxt = CW'(1);
                    err_nxt = 1'b0;
                end
                default: ;
            endcase
        end

        if (do_pop) begin
            stk_nxt[0] = pop_val;
            for (int unsigned i = 1; i < DEPTH - 1; i++)
                stk_nxt[i] = stk[i+1];
            stk_nxt[DEPTH-1] = '0;
            cnt_nxt = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                stk[i] <= '0;
            cnt_q <= CW'(1);
            err_q <= 1'b0;
        end else begin
            stk   <= stk_nxt;
            cnt_q <= cnt_nxt;
            err_q <= err_nxt;
        end
    end

    assign top   = stk[0];
    assign next  = stk[1];
    assign count = cnt_q;
    assign error = err_q;

endmodule

// File: tb/tb_rpn_stack.sv
// Self-checking bench: directed scenarios plus randomized ops against a queue-based model.
module tb_rpn_stack;
    import calc_pkg::*;

    localparam int WA = 16;
    localparam int DA = 4;
    localparam int WB = 8;
    localparam int DB = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          va, vb;
    logic          ready_a, ready_b;
    logic [2:0]    op_code;
    logic [3:0]    digit;
    logic          hex_mode;
    logic [WA-1:0] top_a, next_a;
    logic [2:0]    count_a;
    logic          error_a;
    logic [WB-1:0] top_b, next_b;
    logic [3:0]    count_b;
    logic          error_b;

    int n_vec = 0;
    int n_err = 0;

    int unsigned q[$];
    logic        m_err;

    always #5 clock = ~clock;

    rpn_stack #(.WIDTH(WA), .DEPTH(DA)) u_a (
        .clock(clock), .reset(reset), .op_valid(va), .op_ready(ready_a),
        .op_code(op_code), .digit(digit), .hex_mode(hex_mode),
        .top(top_a), .next(next_a), .count(count_a), .error(error_a)
    );

    rpn_stack #(.WIDTH(WB), .DEPTH(DB)) u_b (
        .clock(clock), .reset(reset), .op_valid(vb), .op_ready(ready_b),
        .op_code(op_code), .digit(digit), .hex_mode(hex_mode),
        .top(top_b), .next(next_b), .count(count_b), .error(error_b)
    );

    task automatic send(input bit to_b, input logic [2:0] op, input logic [3:0] d, input logic h);
        @(negedge clock);
        op_code  = op;
        digit    = d;
        hex_mode = h;
        va       = !to_b;
        vb       = to_b;
        @(posedge clock);
        #1;
        va = 1'b0;
        vb = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        va    = 1'b0;
        vb    = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b1;
        q     = {0};
        m_err = 1'b0;
    endtask

    task automatic model_apply(input logic [2:0] op, input logic [3:0] d, input logic h);
        longint unsigned mask = (64'd1 << WA) - 1;
        longint unsigned r, v, x, y;
        r = h ? 16 : 10;
        case (op)
            OP_DIGIT: begin
                v = longint'(q[0]) * r + d;
                if (d >= r || v > mask) m_err = 1'b1;
                else q[0] = int'(v);
            end
            OP_PUSH: if (q.size() == DA) m_err = 1'b1; else q.push_front(0);
            OP_ADD, OP_SUB, OP_MUL: begin
`ifndef RPN_STACK_MUL_EN
                if (op == OP_MUL) m_err = 1'b1; else
`endif
                if (q.size() < 2) m_err = 1'b1;
                else begin
                    x = q.pop_front();
                    y = q.pop_front();
                    if (op == OP_ADD) v = y + x;
                    else if (op == OP_SUB) v = y - x;
                    else v = y * x;
                    q.push_front(int'(v & mask));
                end
            end
            OP_SWAP: if (q.size() < 2) m_err = 1'b1; else begin
                x = q[0]; q[0] = q[1]; q[1] = int'(x);
            end
            OP_CLEAR: begin q = {0}; m_err = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic test_reset();
        reset = 1'b0; va = 1'b0; vb = 1'b0; op_code = OP_NOP; digit = '0; hex_mode = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_vec++;
        if ({top_a, next_a, count_a, error_a, ready_a} !== {16'd0, 16'd0, 3'd1, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL reset_a: got %h want %h", {top_a, next_a, count_a, error_a, ready_a}, {16'd0, 16'd0, 3'd1, 1'b0, 1'b1});
        end
        n_vec++;
        if ({top_b, next_b, count_b, error_b, ready_b} !== {8'd0, 8'd0, 4'd1, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL reset_b: got %h want %h", {top_b, next_b, count_b, error_b, ready_b}, {8'd0, 8'd0, 4'd1, 1'b0, 1'b1});
        end
        @(negedge clock);
        reset = 1'b1;
        send(0, OP_DIGIT, 4'd7, 1'b0);
        send(0, OP_PUSH, 4'd0, 1'b0);
        send(0, OP_ADD, 4'd0, 1'b0);
        send(0, OP_SWAP, 4'd0, 1'b0);
        // reset wins over a simultaneous PUSH
        @(negedge clock);
        reset = 1'b0; op_code = OP_PUSH; va = 1'b1;
        @(posedge clock);
        #1;
        n_vec++;
        if ({top_a, next_a, count_a, error_a} !== {16'd0, 16'd0, 3'd1, 1'b0}) begin
            n_err++; $display("FAIL reset_priority: got %h want %h", {top_a, next_a, count_a, error_a}, {16'd0, 16'd0, 3'd1, 1'b0});
        end
        @(negedge clock);
        va = 1'b0; reset = 1'b1;
    endtask

    task automatic test_digit_add_sub();
        do_reset();
        send(0, OP_DIGIT, 4'd1, 1'b0);
        send(0, OP_DIGIT, 4'd2, 1'b0);
        send(0, OP_DIGIT, 4'd3, 1'b0);
        n_vec++;
        if ({top_a, count_a, error_a} !== {16'd123, 3'd1, 1'b0}) begin
            n_err++; $display("FAIL digit_123: got %h want %h", {top_a, count_a, error_a}, {16'd123, 3'd1, 1'b0});
        end
        send(0, OP_PUSH, 4'd0, 1'b0);
        send(0, OP_DIGIT, 4'd9, 1'b0);
        send(0, OP_DIGIT, 4'd0, 1'b0);
        send(0, OP_DIGIT, 4'd0, 1'b0);
        n_vec++;
        if ({top_a, next_a, count_a} !== {16'd900, 16'd123, 3'd2}) begin
            n_err++; $display("FAIL push_900: got %h want %h", {top_a, next_a, count_a}, {16'd900, 16'd123, 3'd2});
        end
        send(0, OP_ADD, 4'd0, 1'b0);
        n_vec++;
        if ({top_a, next_a, count_a, error_a} !== {16'd1023, 16'd0, 3'd1, 1'b0}) begin
            n_err++; $display("FAIL add_1023: got %h want %h", {top_a, next_a, count_a, error_a}, {16'd1023, 16'd0, 3'd1, 1'b0});
        end
        send(0, OP_PUSH, 4'd0, 1'b0);
        send(0, OP_DIGIT, 4'd8, 1'b0);
        send(0, OP_SUB, 4'd0, 1'b0);
        n_vec++;
        if ({top_a, next_a, count_a, error_a} !== {16'd1015, 16'd0, 3'd1, 1'b0}) begin
            n_err++; $display("FAIL sub_1015: got %h want %h", {top_a, next_a, count_a, error_a}, {16'd1015, 16'd0, 3'd1, 1'b0});
        end
    endtask

    task automatic test_underflow_clear();
        do_reset();
        send(0, OP_DIGIT, 4'd5, 1'b0);
        send(0, OP_ADD, 4'd0, 1'b0);
        n_vec++;
        if ({top_a, count_a, error_a} !== {16'd5, 3'd1, 1'b1}) begin
            n_err++; $display("FAIL add_underflow: got %h want %h", {top_a, count_a, error_a}, {16'd5, 3'd1, 1'b1});
        end
        send(0, OP_DIGIT, 4'd2, 1'b0);
        n_vec++;
        if ({top_a, error_a} !== {16'd52, 1'b1}) begin
            n_err++; $display("FAIL error_sticky: got %h want %h", {top_a, error_a}, {16'd52, 1'b1});
        end
        send(0, OP_CLEAR, 4'd0, 1'b0);
        n_vec++;
        if ({top_a, next_a, count_a, error_a} !== {16'd0, 16'd0, 3'd1, 1'b0}) begin
            n_err++; $display("FAIL clear: got %h want %h", {top_a, next_a, count_a, error_a}, {16'd0, 16'd0, 3'd1, 1'b0});
        end
    endtask

    task automatic test_overflow_depth();
        do_reset();
        repeat (3) send(0, OP_PUSH, 4'd0, 1'b0);
        n_vec++;
        if ({count_a, error_a} !== {3'd4, 1'b0}) begin
            n_err++; $display("FAIL push_to_full: got %h want %h", {count_a, error_a}, {3'd4, 1'b0});
        end
        send(0, OP_PUSH, 4'd0, 1'b0);
        n_vec++;
        if ({count_a, error_a} !== {3'd4, 1'b1}) begin
            n_err++; $display("FAIL push_full: got %h want %h", {count_a, error_a}, {3'd4, 1'b1});
        end
        send(0, OP_DIGIT, 4'hB, 1'b0);
        n_vec++;
        if ({top_a, count_a, error_a} !== {16'd0, 3'd4, 1'b1}) begin
            n_err++; $display("FAIL digit_radix: got %h want %h", {top_a, count_a, error_a}, {16'd0, 3'd4, 1'b1});
        end
    endtask

    task automatic test_hex_width8();
        do_reset();
        send(1, OP_DIGIT, 4'hF, 1'b1);
        send(1, OP_DIGIT, 4'hF, 1'b1);
        n_vec++;
        if ({top_b, count_b, error_b} !== {8'hFF, 4'd1, 1'b0}) begin
            n_err++; $display("FAIL hex_ff: got %h want %h", {top_b, count_b, error_b}, {8'hFF, 4'd1, 1'b0});
        end
        send(1, OP_DIGIT, 4'h1, 1'b1);
        n_vec++;
        if ({top_b, error_b} !== {8'hFF, 1'b1}) begin
            n_err++; $display("FAIL hex_overflow: got %h want %h", {top_b, error_b}, {8'hFF, 1'b1});
        end
    endtask

    task automatic test_mul();
        int low;
        do_reset();
        send(0, OP_DIGIT, 4'd1, 1'b0);
        send(0, OP_DIGIT, 4'd2, 1'b0);
        send(0, OP_PUSH, 4'd0, 1'b0);
        send(0, OP_DIGIT, 4'd3, 1'b0);
        send(0, OP_DIGIT, 4'd4, 1'b0);
        send(0, OP_MUL, 4'd0, 1'b0);
`ifdef RPN_STACK_MUL_EN
        low = 0;
        while (ready_a === 1'b0 && low < 40) begin
            n_vec++;
            if ({top_a, next_a, count_a} !== {16'd34, 16'd12, 3'd2}) begin
                n_err++; $display("FAIL mul_hold: got %h want %h", {top_a, next_a, count_a}, {16'd34, 16'd12, 3'd2});
            end
            low++;
            @(posedge clock);
            #1;
        end
        n_vec++;
        if (low !== WA) begin
            n_err++; $display("FAIL mul_busy_cycles: got %0d want %0d", low, WA);
        end
        n_vec++;
        if ({top_a, next_a, count_a, error_a} !== {16'd408, 16'd0, 3'd1, 1'b0}) begin
            n_err++; $display("FAIL mul_result: got %h want %h", {top_a, next_a, count_a, error_a}, {16'd408, 16'd0, 3'd1, 1'b0});
        end
        send(0, OP_PUSH, 4'd0, 1'b0);
        send(0, OP_DIGIT, 4'd3, 1'b0);
        send(0, OP_MUL, 4'd0, 1'b0);
        repeat (5) @(posedge clock);
        do_reset();
        #1;
        n_vec++;
        if ({top_a, count_a, ready_a} !== {16'd0, 3'd1, 1'b1}) begin
            n_err++; $display("FAIL mul_abort: got %h want %h", {top_a, count_a, ready_a}, {16'd0, 3'd1, 1'b1});
        end
        repeat (20) @(posedge clock);
        #1;
        n_vec++;
        if ({top_a, next_a, count_a, error_a, ready_a} !== {16'd0, 16'd0, 3'd1, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL mul_no_writeback: got %h want %h", {top_a, next_a, count_a, error_a, ready_a}, {16'd0, 16'd0, 3'd1, 1'b0, 1'b1});
        end
`else
        low = 0;
        n_vec++;
        if ({top_a, next_a, count_a, error_a, ready_a} !== {16'd34, 16'd12, 3'd2, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL mul_disabled: got %h want %h", {top_a, next_a, count_a, error_a, ready_a}, {16'd34, 16'd12, 3'd2, 1'b1, 1'b1});
        end
`endif
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [3:0]  d;
        logic        h;
        logic [35:0] exp;
        int          waited, want_wait;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) op = OP_DIGIT;
            d = 4'($urandom_range(0, 15));
            h = 1'($urandom_range(0, 1));
            want_wait = 0;
`ifdef RPN_STACK_MUL_EN
            if (op == OP_MUL && q.size() >= 2) want_wait = WA;
`endif
            send(0, op, d, h);
            model_apply(op, d, h);
            waited = 0;
            while (ready_a !== 1'b1 && waited < 40) begin
                @(posedge clock);
                #1;
                waited++;
            end
            n_vec++;
            if (waited !== want_wait) begin
                n_err++; $display("FAIL rand_busy op=%0d: got %0d want %0d", op, waited, want_wait);
            end
            exp = {16'(q[0]), 16'((q.size() > 1) ? q[1] : 0), 3'(q.size()), m_err};
            n_vec++;
            if ({top_a, next_a, count_a, error_a} !== exp) begin
                n_err++; $display("FAIL rand_state op=%0d d=%0d h=%0d: got %h want %h", op, d, h, {top_a, next_a, count_a, error_a}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_digit_add_sub();
        test_underflow_clear();
        test_overflow_depth();
        test_hex_width8();
        test_mul();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rpn_stack.md
RPN_STACK -- requirements
Module: rpn_stack

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and result width in bits.
REQ-002 Parameter DEPTH, default 8, sets the maximum number of stack entries; legal range 2..64.
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 Port op_valid, input, 1 bit: an operation request is present.
REQ-006 Port op_ready, output, 1 bit: the block can accept an operation.
REQ-007 Port op_code, input, 3 bits: 0 NOP, 1 DIGIT, 2 PUSH, 3 ADD, 4 SUB, 5 MUL, 6 SWAP, 7 CLEAR.
REQ-008 Port digit, input, 4 bits: digit value for DIGIT.
REQ-009 Port hex_mode, input, 1 bit: 1 selects radix 16, 0 selects radix 10.
REQ-010 Port top, output, WIDTH bits: the stack top entry.
REQ-011 Port next, output, WIDTH bits: the second entry, or 0 when count < 2.
REQ-012 Port count, output, clog2(DEPTH+1) bits: the number of live entries.
REQ-013 Port error, output, 1 bit: sticky illegal-operation flag.

Function
REQ-014 An operation is accepted on a rising edge with op_valid=1 and op_ready=1; non-MUL results are visible the following cycle.
REQ-015 op_ready shall be 1 except while a MUL is in progress.
REQ-016 DIGIT: top <= top*radix + digit; if digit >= radix, or the result exceeds 2^WIDTH-1, set error and leave top unchanged.
REQ-017 PUSH: shift the stack down, top <= 0, count+1; if count == DEPTH, set error and make no change.
REQ-018 ADD/SUB: top <= next + top or next - top (modulo 2^WIDTH, wrap silently); pop one entry; count-1.
REQ-019 ADD, SUB, MUL or SWAP with count < 2: set error; stack unchanged.
REQ-020 SWAP: exchange top and next; count unchanged.
REQ-021 CLEAR: top <= 0, all deeper entries <= 0, count <= 1, error <= 0.
REQ-022 NOP: no state change.
REQ-023 error shall be cleared only by CLEAR or reset; successful operations leave it as is.
REQ-024 Entries at positions >= count shall read as 0; next shall be 0 whenever count == 1.
REQ-025 hex_mode is sampled at acceptance of each DIGIT only.
REQ-026 count shall never reach 0 and never exceed DEPTH.

Reset
REQ-027 With reset=0 at a rising edge: top=0, next=0, all entries 0, count=1, error=0, op_ready=1, and any MUL in progress is aborted with no write-back.
REQ-028 Reset shall take priority over a simultaneous op_valid.

Configuration
REQ-029 With macro RPN_STACK_MUL_EN defined, MUL computes top <= low WIDTH bits of next*top, pops one entry, and writes back exactly WIDTH cycles after acceptance.
REQ-030 During a MUL, op_ready=0, and top, next and count hold their pre-MUL values until write-back.
REQ-031 Without RPN_STACK_MUL_EN, op_code 5 sets error in one cycle, leaves the stack unchanged, and op_ready stays 1.

Structure
REQ-032 Package calc_pkg shall hold the op_code enumeration and the radix constants (10, 16).
REQ-033 Sub-module rpn_mul_seq shall implement the iterative shift-add multiplier (start/done handshake) and is instantiated only under RPN_STACK_MUL_EN.

Verification
REQ-034 Scenario: after reset, DIGIT 1, 2, 3 (decimal) -> top=123, count=1, error=0.
REQ-035 Scenario: from top=123, PUSH, DIGIT 9, 0, 0, ADD -> top=1023, next=0, count=1; then PUSH, DIGIT 8, SUB -> top=1015, count=1.
REQ-036 Scenario: ADD with count=1 -> error=1, top unchanged; then CLEAR -> error=0, top=0, count=1.
REQ-037 Scenario: DEPTH=4, three PUSHes (count=4), a fourth PUSH -> error=1, count=4; DIGIT 0xB with hex_mode=0 -> error stays set, top unchanged.
REQ-038 Scenario (macro on, WIDTH=16): top=34, next=12, MUL -> op_ready low for 16 cycles, then top=408, count-1; reset asserted mid-MUL -> top=0, count=1, no write-back.
REQ-039 Scenario: hex_mode=1, DIGIT 0xF, 0xF at WIDTH=8 -> top=0xFF; another DIGIT 1 -> error=1, top=0xFF.
